// File: rtl/hnm_row_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hnm_row_scanner: sweeps HNM rows, buffers the row words and streams each  |
// | fired SSID {row, col} over valid/ready.                 Rev 1.0          |
// +--------------------------------------------------------------------------+
module hnm_row_scanner #(
  parameter int NROWS_HNM        = 16,
  parameter int NCOLS_HNM        = 16,
  parameter int ROWINDEXBITS_HNM = 4,
  parameter int COLINDEXBITS_HNM = 4,
  parameter int READ_LATENCY     = 2,
  parameter int ROWFIFO_DEPTH    = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       hnm_busy,
  output logic                                       readRow,
  output logic [ROWINDEXBITS_HNM-1:0]                rowRead,
  input  logic [ROWINDEXBITS_HNM-1:0]                rowPassed,
  input  logic [NCOLS_HNM-1:0]                       rowReadOutput,
  output logic [ROWINDEXBITS_HNM+COLINDEXBITS_HNM-1:0] ssid_out,
  output logic                                       ssid_valid,
  input  logic                                       ssid_ready,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       row_error
);

  localparam int PW = $clog2(ROWFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(ROWFIFO_DEPTH);
  localparam logic [ROWINDEXBITS_HNM-1:0] LAST_ROW = ROWINDEXBITS_HNM'(NROWS_HNM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t                                       state, state_nx;
  logic [ROWINDEXBITS_HNM-1:0]                  row_cnt, issue_row;
  logic                                         start_ok, issue, last_issue, done_nx, busy_nx;
  logic [CW-1:0]                                inflight, fifo_count;
  logic [CW:0]                                  occupancy;
  logic [READ_LATENCY-1:0]                      pipe_v;
  logic [READ_LATENCY-1:0][ROWINDEXBITS_HNM-1:0] pipe_row;
  logic [NCOLS_HNM-1:0]                         fifo_word [ROWFIFO_DEPTH];
  logic [ROWINDEXBITS_HNM-1:0]                  fifo_row  [ROWFIFO_DEPTH];
  logic [PW-1:0]                                wr_ptr, rd_ptr;
  logic                                         push, enc_load, out_free, take, drain_done;
  logic [NCOLS_HNM-1:0]                         enc_word, enc_rest;
  logic [ROWINDEXBITS_HNM-1:0]                  enc_row;
  logic [COLINDEXBITS_HNM-1:0]                  enc_col;

  // Reads are only issued when FIFO plus in-flight leaves a slot for the return.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
  assign push       = pipe_v[READ_LATENCY-1];
  assign out_free   = !ssid_valid || ssid_ready;
  assign take       = out_free && (enc_word != '0);
  assign enc_rest   = enc_word & (enc_word - NCOLS_HNM'(1));
  assign enc_load   = (fifo_count != '0) && ((enc_word == '0) || (take && (enc_rest == '0)));
  assign drain_done = (inflight == '0) && (fifo_count == '0) && (enc_word == '0) && !ssid_valid;

  always_comb begin
    enc_col = '0;
    for (int i = NCOLS_HNM - 1; i >= 0; i--) begin
      if (enc_word[i]) enc_col = COLINDEXBITS_HNM'(i);
    end
  end

  always_comb begin
    state_nx   = state;
    done_nx    = 1'b0;
    start_ok   = (state == S_IDLE) && start && !busy;
    issue_row  = start_ok ? '0 : row_cnt;
    issue      = (start_ok || (state == S_SCAN)) && !hnm_busy && (occupancy < DEPTH_C);
    last_issue = issue && (issue_row == LAST_ROW);
    case (state)
      S_IDLE:  if (start_ok) state_nx = last_issue ? S_DRAIN : S_SCAN;
      S_SCAN:  if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) begin
                 state_nx = S_IDLE;
                 done_nx  = 1'b1;
               end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE) || done_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readRow    <= 1'b0;
      rowRead    <= '0;
      row_cnt    <= '0;
      inflight   <= '0;
      pipe_v     <= '0;
      pipe_row   <= '0;
      row_error  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      enc_word   <= '0;
      enc_row    <= '0;
      ssid_out   <= '0;
      ssid_valid <= 1'b0;
    end else begin
      readRow <= issue;
      if (issue) rowRead <= issue_row;
      if (issue && !last_issue) row_cnt <= issue_row + ROWINDEXBITS_HNM'(1);
      else if (start_ok)        row_cnt <= '0;

      if (issue && !push)      inflight <= inflight + CW'(1);
      else if (!issue && push) inflight <= inflight - CW'(1);

      pipe_v[0]   <= readRow;
      pipe_row[0] <= rowRead;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_row[i] <= pipe_row[i-1];
      end

      // The tag from the shift register is authoritative; the echo only flags errors.
      if (start_ok)                                                    row_error <= 1'b0;
      else if (push && (rowPassed != pipe_row[READ_LATENCY-1]))        row_error <= 1'b1;

      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (enc_load) rd_ptr <= rd_ptr + PW'(1);
      if (push && !enc_load)      fifo_count <= fifo_count + CW'(1);
      else if (!push && enc_load) fifo_count <= fifo_count - CW'(1);

      if (enc_load) begin
        enc_word <= fifo_word[rd_ptr];
        enc_row  <= fifo_row[rd_ptr];
      end else if (take) begin
        enc_word <= enc_rest;
      end

      if (take) begin
        ssid_out   <= {enc_row, enc_col};
        ssid_valid <= 1'b1;
      end else if (ssid_ready) begin
        ssid_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr] <= rowReadOutput;
      fifo_row[wr_ptr]  <= pipe_row[READ_LATENCY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hnm_row_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hnm_row_scanner: directed scans against an HNM model and SSID         |
// | scoreboard.                                             Rev 1.0          |
// +--------------------------------------------------------------------------+
module tb_hnm_row_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       hnm_busy = 1'b0;
  logic       ssid_ready = 1'b0;
  logic       readRow;
  logic [3:0] rowRead;
  logic [3:0] rowPassed;
  logic [15:0] rowReadOutput;
  logic [7:0] ssid_out;
  logic       ssid_valid, busy, done, row_error;

  hnm_row_scanner #(
    .NROWS_HNM(16), .NCOLS_HNM(16), .ROWINDEXBITS_HNM(4), .COLINDEXBITS_HNM(4),
    .READ_LATENCY(2), .ROWFIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hnm_busy(hnm_busy),
    .readRow(readRow), .rowRead(rowRead), .rowPassed(rowPassed),
    .rowReadOutput(rowReadOutput), .ssid_out(ssid_out), .ssid_valid(ssid_valid),
    .ssid_ready(ssid_ready), .busy(busy), .done(done), .row_error(row_error)
  );

  always #5 clk = ~clk;

  // HNM model: row word appears two cycles after the readRow cycle.
  logic [15:0] hnm [16];
  logic [1:0]  lv = '0;
  logic [3:0]  lr [2];
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    lv    <= {lv[0], readRow};
    lr[0] <= rowRead;
    lr[1] <= lr[0];
  end
  assign rowReadOutput = lv[1] ? hnm[lr[1]] : 16'hDEAD;
  assign rowPassed     = lr[1] ^ ((corrupt && lr[1] == 4'd5) ? 4'h2 : 4'h0);

  int passed = 0, total = 0;
  int reads_cnt, valid_cnt, done_cnt, acc_cnt;
  logic [3:0] read_rows [$];
  logic [7:0] sb [$];
  logic       prev_hb = 1'b0, hold_pending = 1'b0;
  logic [7:0] held;
  int ready_mode = 0, hb_lo = -1, hb_hi = -2, extra_start_k = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else begin
      if (readRow) begin
        reads_cnt++;
        read_rows.push_back(rowRead);
        check("read_while_hnm_busy", {31'b0, prev_hb}, 32'd0);
      end
      if (hold_pending) begin
        check("hold_valid", {31'b0, ssid_valid}, 32'd1);
        check("hold_data", {24'b0, ssid_out}, {24'b0, held});
      end
      if (ssid_valid) valid_cnt++;
      if (ssid_valid && ssid_ready) begin
        acc_cnt++;
        if (sb.size() > 0) check("ssid", {24'b0, ssid_out}, {24'b0, sb.pop_front()});
        else check("ssid_unexpected", {24'b0, ssid_out}, 32'hFFFF_FFFF);
      end
      hold_pending = ssid_valid && !ssid_ready;
      held         = ssid_out;
      if (done) done_cnt++;
    end
    prev_hb = hnm_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    reads_cnt = 0; valid_cnt = 0; done_cnt = 0; acc_cnt = 0;
    read_rows.delete();
    sb.delete();
    hb_lo = -1; hb_hi = -2; extra_start_k = -1;
  endtask

  task automatic load_hnm(input logic [15:0] fill);
    for (int r = 0; r < 16; r++) hnm[r] = fill;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (hnm[r][c]) sb.push_back({r[3:0], c[3:0]});
  endtask

  task automatic drive_cycle(input int k);
    case (ready_mode)
      0: ssid_ready = 1'b1;
      1: ssid_ready = k[0];
      default: ssid_ready = 1'b0;
    endcase
    hnm_busy = (k >= hb_lo) && (k <= hb_hi);
    start    = (k == extra_start_k);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_t1"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < max_cyc) begin
      drive_cycle(k);
      step();
      k++;
    end
    start = 1'b0;
    hnm_busy = 1'b0;
    check({tag, "_done_seen"}, done_cnt - d0, 32'd1);
    step();
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_once"}, done_cnt, 32'd1);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_nreads"}, read_rows.size(), 32'd16);
    for (int i = 0; i < read_rows.size() && i < 16; i++)
      check($sformatf("%s_row%0d", tag, i), {28'b0, read_rows[i]}, i);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_readRow"}, {31'b0, readRow}, 32'd0);
    check({tag, "_rowRead"}, {28'b0, rowRead}, 32'd0);
    check({tag, "_ssid_out"}, {24'b0, ssid_out}, 32'd0);
    check({tag, "_ssid_valid"}, {31'b0, ssid_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_row_error"}, {31'b0, row_error}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    load_hnm(16'h0);
    repeat (3) step();
    check_outputs_zero("reset");
    reset = 1'b1;
    step();

    // Empty map: every row read, nothing emitted.
    clear_stats(); ready_mode = 0; ssid_ready = 1'b1;
    pulse_start("empty");
    check("empty_first_readRow", {31'b0, readRow}, 32'd1);
    check("empty_first_row", {28'b0, rowRead}, 32'd0);
    wait_done(400, "empty");
    check_reads("empty");
    check("empty_no_valid", valid_cnt, 32'd0);

    // Sparse bits with a spurious start mid-scan.
    clear_stats(); load_hnm(16'h0);
    hnm[4] = 16'h0042; hnm[8] = 16'h0001; hnm[12] = 16'h0080;
    push_expected(); extra_start_k = 5;
    pulse_start("sparse");
    wait_done(400, "sparse");
    check_reads("sparse");
    check("sparse_acc", acc_cnt, 32'd4);

    // Full row with toggling ready.
    clear_stats(); load_hnm(16'h0); hnm[3] = 16'hFFFF; ready_mode = 1;
    push_expected();
    pulse_start("toggle");
    wait_done(600, "toggle");
    check("toggle_acc", acc_cnt, 32'd16);

    // Full map under held-off ready: issue bounded by buffer depth + encoder.
    clear_stats(); load_hnm(16'hFFFF); ready_mode = 2; ssid_ready = 1'b0;
    push_expected();
    pulse_start("stall_out");
    for (int k = 0; k < 60; k++) begin drive_cycle(k); step(); end
    check("stall_out_reads", reads_cnt, 32'd5);
    ready_mode = 0;
    wait_done(2000, "stall_out");
    check_reads("stall_out");
    check("stall_out_acc", acc_cnt, 32'd256);

    // HNM busy window.
    clear_stats(); load_hnm(16'h0);
    hnm[4] = 16'h0042; hnm[8] = 16'h0001; hnm[12] = 16'h0080;
    push_expected(); hb_lo = 3; hb_hi = 10;
    pulse_start("hnmbusy");
    wait_done(400, "hnmbusy");
    check_reads("hnmbusy");
    check("hnmbusy_acc", acc_cnt, 32'd4);

    // Corrupted echo on row 5.
    clear_stats(); load_hnm(16'h0); corrupt = 1'b1;
    hnm[5] = 16'h0104; hnm[9] = 16'h8000;
    push_expected();
    pulse_start("corrupt");
    wait_done(400, "corrupt");
    check("corrupt_row_error", {31'b0, row_error}, 32'd1);
    corrupt = 1'b0;

    // New start clears the error; reset mid-scan aborts without done.
    clear_stats(); load_hnm(16'hFFFF); push_expected();
    pulse_start("abort");
    check("abort_error_cleared", {31'b0, row_error}, 32'd0);
    for (int k = 0; k < 20; k++) begin drive_cycle(k); step(); end
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    sb.delete();
    repeat (4) step();
    reset = 1'b1;
    repeat (40) step();
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
